// File: rtl/seq_shift_add_mul_if.sv
// Start/done strobe handshake between a requester (PID core) and the shift-add multiplier.
// Operand and product buses are 2N bits wide.
interface seq_shift_add_mul_if #(
  parameter int unsigned N = 41
);
  localparam int unsigned W = 2 * N;

  logic         MUL_Start_STRB_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         MUL_Done_STRB_o;
  logic         busy_o;
  logic [W-1:0] out_o;

  modport master (
    output MUL_Start_STRB_i,
    output a_i,
    output b_i,
    input  MUL_Done_STRB_o,
    input  busy_o,
    input  out_o
  );

  modport slave (
    input  MUL_Start_STRB_i,
    input  a_i,
    input  b_i,
    output MUL_Done_STRB_o,
    output busy_o,
    output out_o
  );
endinterface

// File: rtl/seq_shift_add_mul.sv
// Sequential signed shift-add multiplier: one add/shift step every CLK_DIV_MULTIPLIER clocks,
// product truncated to 2N bits with a one-cycle done strobe.
module seq_shift_add_mul #(
  parameter int unsigned N                  = 41,
  parameter int unsigned CLK_DIV_MULTIPLIER = 50
) (
  input logic                clk_i,
  input logic                rst_i,
  seq_shift_add_mul_if.slave bus
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned DW = (CLK_DIV_MULTIPLIER > 1) ? $clog2(CLK_DIV_MULTIPLIER) : 1;

  localparam logic [BW-1:0] LastBit = BW'(W - 1);
  localparam logic [DW-1:0] LastDiv = DW'(CLK_DIV_MULTIPLIER - 1);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  out_q;
  logic [BW-1:0] bit_cnt_q;
  logic [DW-1:0] div_cnt_q;
  logic          done_q;
  logic          busy_q;
  logic [W-1:0]  step_sum;

  // Unsigned accumulation mod 2^W yields the correct two's-complement low half.
  always_comb begin
    step_sum = acc_q + (b_q[0] ? a_q : '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.MUL_Start_STRB_i) begin
            a_q       <= bus.a_i;
            b_q       <= bus.b_i;
            acc_q     <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          if (div_cnt_q == LastDiv) begin
            div_cnt_q <= '0;
            acc_q     <= step_sum;
            a_q       <= a_q << 1;
            b_q       <= b_q >> 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) begin
              out_q   <= step_sum;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.MUL_Done_STRB_o = done_q;
  assign bus.busy_o          = busy_q;
  assign bus.out_o           = out_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Scoreboard bench: a small N=4/DIV=2 instance under directed and random traffic, plus the
// default-size instance for the 4100-clock latency case.
module tb_seq_shift_add_mul;

  localparam int unsigned SN   = 4;
  localparam int unsigned SDIV = 2;
  localparam int          SLAT = 2 * SN * SDIV;
  localparam int          BLAT = 2 * 41 * 50;

  typedef struct {
    logic [7:0] val;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_s = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  exp_t       exp_q[$];
  int         acc_edge = 0;
  int         busy_until = 0;
  logic [7:0] exp_out = '0;
  logic       mon_en = 1'b0;
  logic       big_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_shift_add_mul_if #(.N(SN)) sif ();
  seq_shift_add_mul_if #(.N(41)) bif ();

  seq_shift_add_mul #(.N(SN), .CLK_DIV_MULTIPLIER(SDIV)) dut_s (
    .clk_i(clk),
    .rst_i(rst_s),
    .bus  (sif)
  );

  seq_shift_add_mul #(.N(41), .CLK_DIV_MULTIPLIER(50)) dut_b (
    .clk_i(clk),
    .rst_i(rst_b),
    .bus  (bif)
  );

  // Reference: signed integer product, kept modulo 2^8.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    return 8'(sa * sb);
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, got, want);
    end
  endtask

  // Holds start high for len edges; the model decides per edge whether it is accepted.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input int len);
    sif.a_i = a;
    sif.b_i = b;
    for (int k = 0; k < len; k++) begin
      int e0;
      sif.MUL_Start_STRB_i = 1'b1;
      e0 = cyc + 1;
      if (e0 > busy_until) begin
        exp_q.push_back('{val: ref_mul(a, b), due: e0 + SLAT});
        acc_edge   = e0;
        busy_until = e0 + SLAT;
      end
      @(negedge clk);
    end
    sif.MUL_Start_STRB_i = 1'b0;
    sif.a_i = 8'($urandom);
    sif.b_i = 8'($urandom);
  endtask

  task automatic pulse_reset();
    rst_s = 1'b1;
    exp_q.delete();
    busy_until = 0;
    acc_edge   = 0;
    exp_out    = '0;
    @(negedge clk);
    rst_s = 1'b0;
  endtask

  // Monitor for the small instance.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (sif.MUL_Done_STRB_o) begin
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("product", sif.out_o, e.val);
          exp_out = e.val;
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check("missed_done", 0, 1);
        void'(exp_q.pop_front());
      end
      check("busy", sif.busy_o, (cyc >= acc_edge) && (cyc < busy_until));
      check("out_hold", sif.out_o, exp_out);
    end
  end

  // Default-size instance: 3*7 with the full 82*50 latency.
  initial begin
    int e0b;
    bif.MUL_Start_STRB_i = 1'b0;
    bif.a_i = '0;
    bif.b_i = '0;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    check("big_reset_out", bif.out_o, 0);
    check("big_reset_busy", bif.busy_o, 0);
    bif.a_i = 82'd3;
    bif.b_i = 82'd7;
    bif.MUL_Start_STRB_i = 1'b1;
    e0b = cyc + 1;
    @(negedge clk);
    bif.MUL_Start_STRB_i = 1'b0;
    bif.a_i = 82'd12345;
    bif.b_i = 82'd999;
    for (int i = 0; i < BLAT + 100; i++) begin
      @(posedge clk);
      #1;
      if (bif.MUL_Done_STRB_o !== (cyc == e0b + BLAT))
        check("big_done_timing", bif.MUL_Done_STRB_o, cyc == e0b + BLAT);
      if (bif.busy_o !== (cyc < e0b + BLAT))
        check("big_busy", bif.busy_o, cyc < e0b + BLAT);
      if (cyc == e0b + BLAT) begin
        check("big_done", bif.MUL_Done_STRB_o, 1);
        check("big_product", bif.out_o, 21);
      end
    end
    check("big_out_hold", bif.out_o, 21);
    big_done = 1'b1;
  end

  initial begin
    sif.MUL_Start_STRB_i = 1'b0;
    sif.a_i = '0;
    sif.b_i = '0;
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
    check("reset_out", sif.out_o, 0);
    check("reset_busy", sif.busy_o, 0);
    check("reset_done", sif.MUL_Done_STRB_o, 0);
    mon_en = 1'b1;

    issue(8'd5, 8'hFD, 1);
    repeat (SLAT + 4) @(negedge clk);
    issue(8'hFC, 8'hFA, 1);
    repeat (SLAT + 4) @(negedge clk);
    issue(8'd16, 8'd16, 1);
    repeat (SLAT + 4) @(negedge clk);
    issue(8'h7F, 8'd2, 1);
    repeat (SLAT + 4) @(negedge clk);
    issue(8'd0, 8'h55, 1);
    repeat (SLAT + 4) @(negedge clk);

    // Start while computing must be ignored.
    issue(8'd2, 8'd3, 1);
    repeat (4) @(negedge clk);
    issue(8'h11, 8'h22, 1);
    repeat (SLAT + 4) @(negedge clk);

    // Reset mid-operation discards the product.
    issue(8'd1, 8'd2, 1);
    repeat (6) @(negedge clk);
    pulse_reset();
    repeat (3) @(negedge clk);
    issue(8'hFF, 8'hFF, 1);
    repeat (SLAT + 4) @(negedge clk);

    // Start in the done cycle is accepted.
    issue(8'd3, 8'd5, 1);
    for (int i = 0; i < 4 * SLAT && !sif.MUL_Done_STRB_o; i++) @(negedge clk);
    check("done_seen", sif.MUL_Done_STRB_o, 1);
    issue(8'd9, 8'd9, 1);
    repeat (SLAT + 4) @(negedge clk);

    // Held start re-triggers once per idle entry.
    issue(8'd6, 8'hF9, SLAT + 4);
    repeat (SLAT + 4) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      issue(ra, rb, $urandom_range(1, 3));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    repeat (SLAT + 8) @(negedge clk);
    for (int i = 0; i < 2 * BLAT && !big_done; i++) @(negedge clk);
    check("big_finished", big_done, 1);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_mul.md
Name: seq_shift_add_mul

Overview:
- Sequential signed shift-add multiplier. It is the responder side of the start/done strobe handshake the PID core uses for its five coefficient products per sample.
- It accepts one operand pair per start strobe and performs one shift-add step every CLK_DIV_MULTIPLIER clocks, trading throughput for area.
- It returns the product truncated to 2N bits, plus a one-cycle done strobe.

Parameters:
- N, 41, multiplier base width. Operands and result are 2N bits wide.
- CLK_DIV_MULTIPLIER, 50, clocks per shift-add step. Must be >= 1.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- MUL_Start_STRB_i  input  1  start strobe; a one-cycle pulse is expected
- a_i  input  2N  signed multiplicand, two's complement
- b_i  input  2N  signed multiplier, two's complement
- MUL_Done_STRB_o  output  1  one-cycle pulse when out_o is updated
- busy_o  output  1  high while a multiplication is in progress
- out_o  output  2N  signed product, low 2N bits of a*b, held between completions

Behaviour:
- Reset: every clk_i edge with rst_i=1 gives state=IDLE, out_o=0, MUL_Done_STRB_o=0, busy_o=0, all internal registers 0. Reset wins over every other event, including mid-operation; the aborted product is discarded and no done strobe follows.
- Registers:
  - a_reg (2N), b_reg (2N), acc (2N).
  - bit_cnt: counts 0..2N-1, width ceil(log2(2N)).
  - div_cnt: counts 0..CLK_DIV_MULTIPLIER-1.
- State IDLE:
  - busy_o=0.
  - If MUL_Start_STRB_i=1 at an edge: latch a_reg<=a_i and b_reg<=b_i; clear acc, bit_cnt and div_cnt; go to CALC.
  - Operands are sampled only at that edge; later changes on a_i/b_i are ignored.
- State CALC:
  - busy_o=1. div_cnt increments every clock.
  - When div_cnt==CLK_DIV_MULTIPLIER-1, do one step:
    - acc <= acc + (b_reg[0] ? a_reg : 0), modulo 2^2N
    - a_reg <= a_reg << 1
    - b_reg <= b_reg >> 1 (logical)
    - bit_cnt++, div_cnt<=0
  - On the step with bit_cnt==2N-1: out_o <= the step's final acc sum, MUL_Done_STRB_o<=1, go to IDLE.
- Arithmetic: unsigned shift-add over 2N bits. Two's-complement truncation makes the result exactly (a*b) mod 2^2N for signed operands. No saturation; overflow wraps.
- Latency: with the start sampled at edge E0, out_o and MUL_Done_STRB_o update at edge E0 + 2N*CLK_DIV_MULTIPLIER. The default is 82*50 = 4100 clocks.
- MUL_Done_STRB_o is high for exactly one cycle and returns to 0 on the next edge. out_o holds its value until the next completion or reset.
- Start strobe handling:
  - A start while in CALC is ignored: no restart, no queuing.
  - A start held high for multiple cycles starts at most one operation per IDLE entry.
  - A start in the cycle where done is high is accepted, since the state is already IDLE. Back-to-back operations therefore have a 2N*CLK_DIV_MULTIPLIER period.
- busy_o rises the cycle after start is accepted and falls in the same cycle that done rises.
- Zero operand: the full latency still applies and out_o=0.

Test Plan:
1. Defaults; a_i=3, b_i=7, single start pulse -> out_o=21, done pulse exactly 4100 clocks after the start edge, busy_o high in between.
2. N=4, DIV=3; a_i=5, b_i=-3 (0xFD) -> out_o=0xF1 (-15), done at start+24 clocks; a_i=-4, b_i=-6 -> out_o=24.
3. N=4, DIV=1; a_i=16, b_i=16 -> out_o=0 (wrap mod 256), done at start+8 clocks; a_i=0x7F, b_i=2 -> out_o=0xFE.
4. N=4, DIV=2; start with a=2, b=3; change a_i/b_i and pulse start again at start+5 -> only one done at start+16 with out_o=6; no second done.
5. N=4, DIV=2; assert rst_i at start+7 -> out_o=0, busy_o=0, no done. New start with a=-1, b=-1 -> out_o=1 at its start+16.
6. N=4, DIV=1; assert start in the same cycle as the done pulse with a=9, b=9 -> accepted; second done 8 clocks later with out_o=81 (0x51).
